// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_sequencer_if.sv
// EX-stage <-> md_sequencer bus: request side plus busy/done/HI/LO return.
interface md_sequencer_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_start, md_op, md_a, md_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  md_start, md_op, md_a, md_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath; result is {hi, lo}.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] a_sx;
  logic [63:0] b_sx;

  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};

  // Select the arithmetic result; divides by zero only raise the flag.
  always_comb begin
    logic [31:0] quo;
    logic [31:0] rem;
    result   = '0;
    div_zero = 1'b0;
    quo      = '0;
    rem      = '0;
    case (op)
      MD_MULT:  result = a_sx * b_sx;
      MD_MULTU: result = {32'h0, a} * {32'h0, b};
      MD_DIV: begin
        if (b == '0) begin
          div_zero = 1'b1;
        end else if (a == 32'h8000_0000 && b == '1) begin
          // Overflow case pinned explicitly rather than left to the operator.
          quo = 32'h8000_0000;
          rem = '0;
        end else begin
          quo = $signed(a) / $signed(b);
          rem = $signed(a) % $signed(b);
        end
        result = {rem, quo};
      end
      MD_DIVU: begin
        if (b == '0) begin
          div_zero = 1'b1;
        end else begin
          quo = a / b;
          rem = a % b;
        end
        result = {rem, quo};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle md sequencer: times mult/div latency, owns HI/LO, aborts on flush.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  md_sequencer_if.slave  bus
);

  // Counter holds cycles remaining after the current busy cycle.
  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  md_state_e   state;
  logic [4:0]  cnt;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend_res;
  logic        pend_dz;

  logic [63:0] calc_res;
  logic        calc_dz;
  logic        accept;

  md_calc u_calc (
    .op       (bus.md_op),
    .a        (bus.md_a),
    .b        (bus.md_b),
    .result   (calc_res),
    .div_zero (calc_dz)
  );

  assign accept = bus.md_start && (state == IDLE) && !bus.flush;

  // Sequencer FSM, latency counter, pending result and HI/LO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      pend_res <= '0;
      pend_dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.md_op)
              MD_MTHI: hi_q <= bus.md_a;
              MD_MTLO: lo_q <= bus.md_a;
              MD_MULT, MD_MULTU: begin
                state    <= RUN;
                busy_q   <= 1'b1;
                cnt      <= MULT_LOAD;
                done_q   <= (MULT_LOAD == 5'd0);
                pend_res <= calc_res;
                pend_dz  <= 1'b0;
              end
              MD_DIV, MD_DIVU: begin
                state    <= RUN;
                busy_q   <= 1'b1;
                cnt      <= DIV_LOAD;
                done_q   <= (DIV_LOAD == 5'd0);
                pend_res <= calc_res;
                pend_dz  <= calc_dz;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
          end else if (cnt == 5'd0) begin
            if (!pend_dz) begin
              hi_q <= pend_res[63:32];
              lo_q <= pend_res[31:0];
            end
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else begin
            cnt    <= cnt - 5'd1;
            done_q <= (cnt == 5'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  // A flush in the final busy cycle cancels the commit, so it also masks done.
  assign bus.done = done_q && !bus.flush;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed ops, monitor checks HI/LO after done.
module tb_md_sequencer;
  import md_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  hilo_t sb[$];

  md_sequencer_if bus ();

  md_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Move into the next cycle, just after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; flush_at=0 means it runs to completion.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned n, input int unsigned flush_at,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    bit commit;
    int unsigned last;
    commit = (flush_at == 0);
    last   = commit ? n : flush_at;
    if (commit) sb.push_back('{hi: eh, lo: el});
    cyc();
    bus.md_start = 1'b1;
    bus.md_op    = op;
    bus.md_a     = a;
    bus.md_b     = b;
    @(negedge clk);
    chk({nm, " busy@T"}, {31'b0, bus.busy}, 32'd0);
    for (int unsigned k = 1; k <= last; k++) begin
      cyc();
      bus.md_start = 1'b0;
      bus.flush    = (k == flush_at);
      @(negedge clk);
      chk($sformatf("%s busy@T+%0d", nm, k), {31'b0, bus.busy}, 32'd1);
      chk($sformatf("%s done@T+%0d", nm, k), {31'b0, bus.done}, {31'b0, (commit && k == n)});
    end
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    chk({nm, " busy end"}, {31'b0, bus.busy}, 32'd0);
    chk({nm, " done end"}, {31'b0, bus.done}, 32'd0);
    if (!commit) begin
      chk({nm, " hi kept"}, bus.hi, eh);
      chk({nm, " lo kept"}, bus.lo, el);
    end
  endtask

  // MTHI then MTLO on consecutive cycles.
  task automatic mt_pair(input logic [31:0] hv, input logic [31:0] lv,
                         input logic [31:0] old_lo, input string nm);
    cyc();
    bus.md_start = 1'b1;
    bus.md_op    = MD_MTHI;
    bus.md_a     = hv;
    cyc();
    bus.md_op    = MD_MTLO;
    bus.md_a     = lv;
    @(negedge clk);
    chk({nm, " hi first"}, bus.hi, hv);
    chk({nm, " lo old"}, bus.lo, old_lo);
    chk({nm, " busy0 a"}, {31'b0, bus.busy}, 32'd0);
    cyc();
    bus.md_start = 1'b0;
    @(negedge clk);
    chk({nm, " lo second"}, bus.lo, lv);
    chk({nm, " hi kept"}, bus.hi, hv);
    chk({nm, " busy0 b"}, {31'b0, bus.busy}, 32'd0);
  endtask

  // Monitor: on done, pop the expected HI/LO and compare in the following cycle.
  initial begin
    hilo_t exp_v;
    bit    pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("sb hi", bus.hi, exp_v.hi);
          chk("sb lo", bus.lo, exp_v.lo);
          pend = 1'b0;
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            chk("unexpected done", 32'd1, 32'd0);
          end else begin
            exp_v = sb.pop_front();
            pend  = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.md_start = 1'b0;
    bus.md_op    = '0;
    bus.md_a     = '0;
    bus.md_b     = '0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst busy", {31'b0, bus.busy}, 32'd0);
    chk("rst done", {31'b0, bus.done}, 32'd0);
    chk("rst hi", bus.hi, 32'd0);
    chk("rst lo", bus.lo, 32'd0);

    run_md(MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult");

    // MULTU with an ignored start mid-run and a start accepted at T+6.
    sb.push_back('{hi: 32'h0000_0001, lo: 32'hFFFF_FFFE});
    cyc();
    bus.md_start = 1'b1;
    bus.md_op    = MD_MULTU;
    bus.md_a     = 32'hFFFF_FFFF;
    bus.md_b     = 32'd2;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      bus.md_start = (k == 3);
      bus.md_op    = MD_MTHI;
      bus.md_a     = 32'h0000_0BAD;
      @(negedge clk);
      chk($sformatf("multu busy@T+%0d", k), {31'b0, bus.busy}, 32'd1);
      chk($sformatf("multu done@T+%0d", k), {31'b0, bus.done}, {31'b0, (k == 5)});
    end
    cyc();
    bus.md_start = 1'b1;
    bus.md_op    = MD_MTLO;
    bus.md_a     = 32'h0000_0055;
    @(negedge clk);
    chk("multu busy@T+6", {31'b0, bus.busy}, 32'd0);
    chk("multu hi no BAD", bus.hi, 32'h0000_0001);
    cyc();
    bus.md_start = 1'b0;
    @(negedge clk);
    chk("mtlo@T+6 lo", bus.lo, 32'h0000_0055);
    chk("mtlo@T+6 hi", bus.hi, 32'h0000_0001);

    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_md(MD_DIVU, 32'd7, 32'd0, 10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu0");
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 32'h0000_0000, 32'h8000_0000, "divovf");
    run_md(MD_DIVU, 32'd100, 32'd7, 10, 0, 32'd2, 32'd14, "divu");

    mt_pair(32'h1111_1111, 32'h2222_2222, 32'd14, "mt1");
    run_md(MD_DIV, 32'd100, 32'd7, 10, 4, 32'h1111_1111, 32'h2222_2222, "flush4");
    run_md(MD_DIV, 32'd100, 32'd7, 10, 10, 32'h1111_1111, 32'h2222_2222, "flush10");

    mt_pair(32'hDEAD_BEEF, 32'h1234_5678, 32'h2222_2222, "mt2");

    // MTHI together with flush must be dropped.
    cyc();
    bus.md_start = 1'b1;
    bus.md_op    = MD_MTHI;
    bus.md_a     = 32'h0000_CAFE;
    bus.flush    = 1'b1;
    cyc();
    bus.md_start = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    chk("mthi flush hi", bus.hi, 32'hDEAD_BEEF);

    // Reserved op code is a no-op.
    cyc();
    bus.md_start = 1'b1;
    bus.md_op    = 3'b110;
    bus.md_a     = 32'h0BAD_0BAD;
    bus.md_b     = 32'd3;
    cyc();
    bus.md_start = 1'b0;
    @(negedge clk);
    chk("rsvd busy", {31'b0, bus.busy}, 32'd0);
    chk("rsvd hi", bus.hi, 32'hDEAD_BEEF);
    chk("rsvd lo", bus.lo, 32'h1234_5678);

    // Asynchronous reset in the middle of a MULT.
    cyc();
    bus.md_start = 1'b1;
    bus.md_op    = MD_MULT;
    bus.md_a     = 32'd5;
    bus.md_b     = 32'd6;
    cyc();
    bus.md_start = 1'b0;
    cyc();
    @(negedge clk);
    chk("pre-rst busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst busy", {31'b0, bus.busy}, 32'd0);
    chk("async rst done", {31'b0, bus.done}, 32'd0);
    chk("async rst hi", bus.hi, 32'd0);
    chk("async rst lo", bus.lo, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;

    run_md(MD_MULT, 32'd3, 32'd4, 5, 0, 32'd0, 32'd12, "mult34");

    repeat (3) @(negedge clk);
    chk("sb drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle sequencer and owner of the HI/LO register pair for the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and times the multiply/divide latency.
- Drives a registered busy that the hazard unit uses to stall MFHI/MFLO and further md ops.
- Aborts in-flight operations on exception/interrupt flush, so HI/LO stay precise.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..31).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..31).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- md_start  in  1  EX-stage md instruction valid this cycle
- md_op  in  3  operation code (see package)
- md_a  in  32  rs operand
- md_b  in  32  rt operand
- flush  in  1  exception/interrupt flush of EX and younger stages
- busy  out  1  operation in flight; registered
- done  out  1  one-cycle pulse in the final busy cycle of a committing operation
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, pending result cleared.
  - Reset mid-operation discards the operation immediately.
- States:
  - IDLE
  - RUN (counting; remembers op kind)
- Accept rule: a start is accepted in cycle T only when md_start=1, state=IDLE, and flush=0.
  - Starts are ignored while in RUN; the pipeline must stall.
  - Starts are ignored in any cycle where flush=1.
- MTHI/MTLO:
  - Accepted in cycle T, writes hi or lo with md_a at the edge ending T.
  - No busy and no done.
  - The other register is unchanged.
- MULT/MULTU/DIV/DIVU:
  - Results are computed from the operands captured at acceptance.
  - Next state RUN; busy=1 in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES).
  - done=1 in cycle T+N only.
  - hi/lo are written at the edge ending T+N and are visible in T+N+1.
  - busy=0 from T+N+1 and state returns to IDLE.
  - A new start is acceptable in T+N+1.
- Arithmetic:
  - MULT is signed 32x32→64 and MULTU is unsigned 32x32→64; {hi,lo} = product.
  - DIV is signed: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU is unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
- Divide by zero (md_b=0): the operation runs the full DIV_CYCLES with busy and done as normal, but hi/lo are left unchanged.
- Flush while in RUN:
  - State returns to IDLE at the next edge, busy=0 next cycle, no done, hi/lo unchanged.
  - A flush in the same cycle as the final busy cycle (T+N) wins: no commit, no done.
- Reserved md_op codes (110, 111) are ignored as no-ops; busy is not asserted.
- hi/lo only change on MTHI/MTLO acceptance or a committing mult/div.

Decomposition:
- Shared package md_pkg:
  - md_op encodings: MD_MULT=000, MD_MULTU=001, MD_DIV=010, MD_DIVU=011, MD_MTHI=100, MD_MTLO=101.
  - State encodings: IDLE, RUN.
  - Default latency constants.
- One sub-module, md_calc: purely combinational and registered at acceptance.
  - Produces the 64-bit result for the four arithmetic ops.
  - Produces the div-by-zero flag.
- Sequencing, counter, flush handling and HI/LO storage live in md_sequencer.

Test Plan:
- MULT a=0xFFFFFFFD (−3), b=5 → busy high cycles T+1..T+5, done at T+5; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at T+6.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE; a second start issued at T+3 is ignored, and the next start is accepted at T+6.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 → busy/done as normal, hi/lo unchanged.
- With hi=0x11111111, lo=0x22222222, DIV started and flush asserted at T+4 → busy=0 at T+5, no done, hi/lo unchanged. Repeat with flush at T+10 → same result.
- MTHI md_a=0xDEADBEEF then MTLO md_a=0x12345678 on back-to-back cycles → hi/lo updated on consecutive edges, busy stays 0. MTHI with flush=1 → ignored.
- rst_n pulled low mid-MULT → busy, done, hi and lo are 0 immediately (asynchronously); after release, a MULT 3×4 gives lo=12, hi=0.
